// File: rtl/sa_pkg.sv
// Shared defaults and element types for the weight-stationary systolic tile.
package sa_pkg;
    localparam int DEF_DATASIZE            = 8;
    localparam int DEF_OUTPUT_BUF_DATASIZE = 32;
    localparam int DEF_ARRAYWIDTH          = 4;
    localparam int DEF_ARRAYHEIGHT         = 4;
    localparam int DEF_DSP_DELAY           = 1;

    typedef logic signed [DEF_DATASIZE-1:0]            elem_t;
    typedef logic signed [DEF_OUTPUT_BUF_DATASIZE-1:0] acc_t;

    // Modulo that stays non-negative, used for ring-buffer pointer arithmetic.
    function automatic int wrap_idx(input int v, input int n);
        return ((v % n) + n) % n;
    endfunction
endpackage

// File: rtl/sa_pe.sv
// Processing element: stationary weight, DD-stage MAC on the partial sum,
// and a DD-stage pass-through of the activation to the right neighbour.
module sa_pe
    import sa_pkg::*;
#(
    parameter int DW = DEF_DATASIZE,
    parameter int AW = DEF_OUTPUT_BUF_DATASIZE,
    parameter int DD = DEF_DSP_DELAY
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_weight_en,
    input  logic [DW-1:0] w_in,
    input  logic [DW-1:0] act_in,
    input  logic [AW-1:0] psum_in,
    output logic [DW-1:0] w_out,
    output logic [DW-1:0] act_out,
    output logic [AW-1:0] psum_out
);
    logic [DW-1:0]          w_q, w_d;
    logic [DD-1:0][DW-1:0]  act_q, act_d;
    logic [DD-1:0][AW-1:0]  psum_q, psum_d;
    logic signed [2*DW-1:0] prod;

    always_comb begin
        w_d       = write_weight_en ? w_in : w_q;
        prod      = (2*DW)'($signed(act_in)) * (2*DW)'($signed(w_q));
        act_d     = act_q;
        psum_d    = psum_q;
        act_d[0]  = act_in;
        // Sign-extended product; the sum wraps at AW bits.
        psum_d[0] = psum_in + AW'(prod);
        for (int i = 1; i < DD; i++) begin
            act_d[i]  = act_q[i-1];
            psum_d[i] = psum_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_q    <= '0;
            act_q  <= '0;
            psum_q <= '0;
        end else begin
            w_q    <= w_d;
            act_q  <= act_d;
            psum_q <= psum_d;
        end
    end

    assign w_out    = w_q;
    assign act_out  = act_q[DD-1];
    assign psum_out = psum_q[DD-1];
endmodule

// File: rtl/systolic_array_top.sv
// N x N weight-stationary matmul tile with input/weight/output buffers.
// Optional RELU_EN macro clamps negative results to zero on output-buffer write.
module systolic_array_top
    import sa_pkg::*;
#(
    parameter int DATASIZE            = DEF_DATASIZE,
    parameter int OUTPUT_BUF_DATASIZE = DEF_OUTPUT_BUF_DATASIZE,
    parameter int ARRAYWIDTH          = DEF_ARRAYWIDTH,
    parameter int ARRAYHEIGHT         = DEF_ARRAYHEIGHT,
    parameter int DSP_DELAY           = DEF_DSP_DELAY
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    input_buffer_load_en,
    input  logic                                    input_buffer_out_en,
    input  logic                                    weight_buffer_load_en,
    input  logic                                    weight_buffer_out_en,
    input  logic                                    write_weight_en,
    input  logic                                    output_buffer_load_en,
    input  logic                                    output_buffer_out_en,
    input  logic [DATASIZE*ARRAYWIDTH-1:0]          in_act,
    input  logic [DATASIZE*ARRAYWIDTH-1:0]          in_weight,
    output logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] out_top
);
    localparam int N  = (ARRAYWIDTH < ARRAYHEIGHT) ? ARRAYWIDTH : ARRAYHEIGHT;
    localparam int DW = DATASIZE;
    localparam int AW = OUTPUT_BUF_DATASIZE;
    localparam int D  = DSP_DELAY;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int WW = $clog2(D * (N - 1) + N + 1);

    logic [N-1:0][N*DW-1:0]       wbuf_q, wbuf_d, ibuf_q, ibuf_d;
    logic [PW-1:0]                wb_wptr_q, wb_wptr_d, wb_rcnt_q, wb_rcnt_d;
    logic [PW-1:0]                ib_wptr_q, ib_wptr_d, ob_rptr_q, ob_rptr_d;
    logic [CW-1:0]                ib_cnt_q, ib_cnt_d;
    logic [WW-1:0]                win_cnt_q, win_cnt_d;
    logic [N-1:0][PW-1:0]         ob_wptr_q, ob_wptr_d;
    logic [N-1:0][N-1:0][AW-1:0]  obuf_q, obuf_d;
    logic [N-1:0][AW-1:0]         out_top_q, out_top_d;
    logic [N*DW-1:0]              w_row, a_row;
    logic [N-1:0][AW-1:0]         push_val;

    logic [N-1:0][N:0][DW-1:0]    act_h;
    logic [N:0][N-1:0][DW-1:0]    w_v;
    logic [N:0][N-1:0][AW-1:0]    psum_v;
    logic                         unused_tail;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return PW'(wrap_idx(int'(p) + 1, N));
    endfunction

    always_comb begin
        wbuf_d    = wbuf_q;
        ibuf_d    = ibuf_q;
        wb_wptr_d = wb_wptr_q;
        wb_rcnt_d = '0;
        ib_wptr_d = ib_wptr_q;
        ib_cnt_d  = '0;
        win_cnt_d = '0;
        ob_wptr_d = ob_wptr_q;
        ob_rptr_d = ob_rptr_q;
        obuf_d    = obuf_q;
        out_top_d = out_top_q;
        w_row     = '0;
        a_row     = '0;

        if (weight_buffer_load_en) begin
            wbuf_d[wb_wptr_q] = in_weight;
            wb_wptr_d         = ptr_inc(wb_wptr_q);
        end
        // Newest row first, so after N shifts down the columns PE row r holds W[r].
        if (weight_buffer_out_en) begin
            w_row     = wbuf_q[PW'(wrap_idx(int'(wb_wptr_q) - 1 - int'(wb_rcnt_q), N))];
            wb_rcnt_d = ptr_inc(wb_rcnt_q);
        end

        if (input_buffer_load_en) begin
            ibuf_d[ib_wptr_q] = in_act;
            ib_wptr_d         = ptr_inc(ib_wptr_q);
        end
        if (input_buffer_out_en) begin
            ib_cnt_d = ib_cnt_q;
            if (int'(ib_cnt_q) < N) begin
                a_row    = ibuf_q[ib_cnt_q[PW-1:0]];
                ib_cnt_d = ib_cnt_q + CW'(1);
            end
        end

        // Column j lags column j-1 by D cycles, so each column has its own window slot.
        if (output_buffer_load_en) begin
            win_cnt_d = win_cnt_q + WW'(1);
            for (int c = 0; c < N; c++) begin
                if (int'(win_cnt_q) >= D * c && int'(win_cnt_q) < D * c + N) begin
                    obuf_d[c][ob_wptr_q[c]] = push_val[c];
                    ob_wptr_d[c]            = ptr_inc(ob_wptr_q[c]);
                end
            end
        end
        if (output_buffer_out_en) begin
            for (int c = 0; c < N; c++) out_top_d[c] = obuf_q[c][ob_rptr_q];
            ob_rptr_d = ptr_inc(ob_rptr_q);
        end
    end

    always_comb begin
        push_val = '0;
        for (int c = 0; c < N; c++) begin
`ifdef RELU_EN
            push_val[c] = psum_v[N][c][AW-1] ? '0 : psum_v[N][c];
`else
            push_val[c] = psum_v[N][c];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wbuf_q    <= '0;
            ibuf_q    <= '0;
            wb_wptr_q <= '0;
            wb_rcnt_q <= '0;
            ib_wptr_q <= '0;
            ib_cnt_q  <= '0;
            win_cnt_q <= '0;
            ob_wptr_q <= '0;
            ob_rptr_q <= '0;
            obuf_q    <= '0;
            out_top_q <= '0;
        end else begin
            wbuf_q    <= wbuf_d;
            ibuf_q    <= ibuf_d;
            wb_wptr_q <= wb_wptr_d;
            wb_rcnt_q <= wb_rcnt_d;
            ib_wptr_q <= ib_wptr_d;
            ib_cnt_q  <= ib_cnt_d;
            win_cnt_q <= win_cnt_d;
            ob_wptr_q <= ob_wptr_d;
            ob_rptr_q <= ob_rptr_d;
            obuf_q    <= obuf_d;
            out_top_q <= out_top_d;
        end
    end

    assign out_top = out_top_q;

    // Lane k is held back k*D cycles so the diagonal wavefront meets the psums.
    for (genvar k = 0; k < N; k++) begin : g_skew
        if (k == 0) begin : g_direct
            assign act_h[0][0] = a_row[DW-1:0];
        end else begin : g_dly
            localparam int L = k * D;
            logic [L-1:0][DW-1:0] sk_q, sk_d;
            always_comb begin
                sk_d    = sk_q;
                sk_d[0] = a_row[DW*k +: DW];
                for (int i = 1; i < L; i++) sk_d[i] = sk_q[i-1];
            end
            always_ff @(posedge clk) begin
                if (!rst) sk_q <= '0;
                else      sk_q <= sk_d;
            end
            assign act_h[k][0] = sk_q[L-1];
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_edge
        assign w_v[0][c]    = w_row[DW*c +: DW];
        assign psum_v[0][c] = '0;
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            sa_pe #(.DW(DW), .AW(AW), .DD(D)) u_pe (
                .clk             (clk),
                .rst             (rst),
                .write_weight_en (write_weight_en),
                .w_in            (w_v[r][c]),
                .act_in          (act_h[r][c]),
                .psum_in         (psum_v[r][c]),
                .w_out           (w_v[r+1][c]),
                .act_out         (act_h[r][c+1]),
                .psum_out        (psum_v[r+1][c])
            );
        end
    end

    // Right-edge activations and bottom-row weights leave the array unused.
    assign unused_tail = ^{act_h, w_v};
endmodule

// File: tb/tb_systolic_array_top.sv
// Directed bench for systolic_array_top: phased passes with hand-derived result matrices.
module tb_systolic_array_top;
    import sa_pkg::*;

    localparam int N  = DEF_ARRAYWIDTH;
    localparam int D  = DEF_DSP_DELAY;
    localparam int DW = DEF_DATASIZE;
    localparam int AW = DEF_OUTPUT_BUF_DATASIZE;
    localparam int WS = 2 * N + D * N;
    localparam int WL = D * (N - 1) + N;
    localparam int PS = WS + WL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic input_buffer_load_en = 1'b0, input_buffer_out_en = 1'b0;
    logic weight_buffer_load_en = 1'b0, weight_buffer_out_en = 1'b0;
    logic write_weight_en = 1'b0;
    logic output_buffer_load_en = 1'b0, output_buffer_out_en = 1'b0;
    logic [DW*N-1:0] in_act = '0, in_weight = '0;
    logic [AW*N-1:0] out_top;

    int checks = 0;
    int failures = 0;
    int am[N][N];
    int wm[N][N];
    int em[N][N];

    systolic_array_top #(
        .DATASIZE(DW), .OUTPUT_BUF_DATASIZE(AW), .ARRAYWIDTH(N),
        .ARRAYHEIGHT(N), .DSP_DELAY(D)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .input_buffer_load_en  (input_buffer_load_en),
        .input_buffer_out_en   (input_buffer_out_en),
        .weight_buffer_load_en (weight_buffer_load_en),
        .weight_buffer_out_en  (weight_buffer_out_en),
        .write_weight_en       (write_weight_en),
        .output_buffer_load_en (output_buffer_load_en),
        .output_buffer_out_en  (output_buffer_out_en),
        .in_act                (in_act),
        .in_weight             (in_weight),
        .out_top               (out_top)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string tag, input logic [AW*N-1:0] exp_row);
        checks++;
        assert (out_top === exp_row) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, out_top, exp_row);
        end
    endtask

    task automatic idle_inputs();
        input_buffer_load_en  = 1'b0;
        input_buffer_out_en   = 1'b0;
        weight_buffer_load_en = 1'b0;
        weight_buffer_out_en  = 1'b0;
        write_weight_en       = 1'b0;
        output_buffer_load_en = 1'b0;
        output_buffer_out_en  = 1'b0;
        in_act                = '0;
        in_weight             = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
    endtask

    function automatic logic [AW*N-1:0] exp_of(input int i);
        logic [AW*N-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) r[AW*j +: AW] = AW'(em[i][j]);
        return r;
    endfunction

    // abort_at >= 0 pulls rst low for that one cycle and ends the pass there.
    task automatic run_pass(input string name, input int abort_at);
        for (int t = 0; t < PS + N; t++) begin
            rst                   = (t == abort_at) ? 1'b0 : 1'b1;
            in_weight             = '0;
            in_act                = '0;
            weight_buffer_load_en = (t < N);
            if (t < N)
                for (int k = 0; k < N; k++) in_weight[DW*k +: DW] = DW'(wm[t][k]);
            input_buffer_load_en  = (t >= N && t < 2 * N);
            weight_buffer_out_en  = (t >= N && t < 2 * N);
            write_weight_en       = (t >= N && t < 2 * N);
            if (t >= N && t < 2 * N)
                for (int k = 0; k < N; k++) in_act[DW*k +: DW] = DW'(am[t-N][k]);
            input_buffer_out_en   = (t >= 2 * N && t < 3 * N);
            output_buffer_load_en = (t >= WS && t < PS);
            output_buffer_out_en  = (t >= PS);
            if (t == PS) check_row({name, "_pre_pop_zero"}, '0);
            step();
            if (t == abort_at) begin
                idle_inputs();
                check_row({name, "_after_abort_zero"}, '0);
                return;
            end
            if (t >= PS) check_row($sformatf("%s_row%0d", name, t - PS), exp_of(t - PS));
        end
        idle_inputs();
        step();
        step();
        check_row({name, "_hold"}, exp_of(N - 1));
    endtask

    initial begin
        do_reset();
        check_row("reset_out_top", '0);

        // Identity weights: results reproduce the activation rows 1..16.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = 4 * i + j + 1;
                wm[i][j] = (i == j) ? 1 : 0;
                em[i][j] = 4 * i + j + 1;
            end
        run_pass("identity", -1);

        // All twos: 4 * (2*2) = 16.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = 2;
                wm[i][j] = 2;
                em[i][j] = 16;
            end
        do_reset();
        run_pass("twos", -1);

        // W = -I, A = 3: raw -3, clamped to 0 when rectified.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = 3;
                wm[i][j] = (i == j) ? -1 : 0;
`ifdef RELU_EN
                em[i][j] = 0;
`else
                em[i][j] = -3;
`endif
            end
        do_reset();
        run_pass("neg_clamp", -1);

        // -128 * -128 = 16384, four terms = 65536.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = -128;
                wm[i][j] = -128;
                em[i][j] = 65536;
            end
        do_reset();
        run_pass("extremes", -1);

        // Abort a pass mid-stream, then a clean all-ones pass gives 4 everywhere.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = 4 * i + j + 1;
                wm[i][j] = 7;
                em[i][j] = 4;
            end
        do_reset();
        run_pass("abort", 2 * N + 1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = 1;
                wm[i][j] = 1;
            end
        run_pass("after_reset", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
